// File: rtl/tt_pkg.sv
// Shared types and widths for the truth-table checker.
//   VEC_W   : width of the stimulus vector {A,B,C,D,E}
//   NUM_VEC : vectors per sweep
//   ERR_W   : mismatch counter width (holds 0..NUM_VEC)
//   CNT_W   : settle timer width (SETTLE_CYCLES 0..15)
package tt_pkg;

  localparam int unsigned VEC_W   = 5;
  localparam int unsigned NUM_VEC = 32;
  localparam int unsigned ERR_W   = 6;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter timing the SETTLE wait.
//   clk, rst_n : clock, async active-low reset
//   load       : load count with load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, holding at zero
//   zero_c     : count is zero (decoded from the count register)
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 32 input combinations of a 5-input combinational block, waits
// SETTLE_CYCLES per vector, captures its response y and compares it against
// the golden table EXPECTED.
//   clk, rst_n    : clock, async active-low reset
//   start         : begin a sweep (accepted only in IDLE, abort has priority)
//   abort         : terminate a sweep in progress, no result reported
//   y             : response of the block under test to vec
//   vec           : stimulus {A,B,C,D,E}, A = vec[4]
//   busy          : sweep in progress
//   done          : one-cycle pulse when a sweep completes
//   pass          : last completed sweep had no mismatches
//   captured      : sampled y, bit i = vector i
//   err_count     : mismatch count, saturating at 32
//   first_err     : lowest mismatching vector index
//   first_err_vld : first_err is meaningful
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int unsigned  SETTLE_CYCLES = 2,
  parameter logic [31:0]  EXPECTED      = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               y,
  output logic [VEC_W-1:0]   vec,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] captured,
  output logic [ERR_W-1:0]   err_count,
  output logic [VEC_W-1:0]   first_err,
  output logic               first_err_vld
);

  localparam bit               HAS_SETTLE  = (SETTLE_CYCLES != 0);
  // Timer is loaded while leaving DRIVE, so it counts SETTLE_CYCLES-1 down to 0
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    HAS_SETTLE ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NUM_VEC);

  state_e           state;
  state_e           next_state;
  logic             accept_start;
  logic             capture;
  logic             do_abort;
  logic             timer_load;
  logic             timer_dec;
  logic             timer_zero_c;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  tt_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero_c   (timer_zero_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    capture      = 1'b0;
    do_abort     = 1'b0;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort && start) begin
          next_state   = ST_DRIVE;
          accept_start = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          next_state = ST_IDLE;
          do_abort   = 1'b1;
        end else if (HAS_SETTLE) begin
          next_state = ST_SETTLE;
          timer_load = 1'b1;
        end else begin
          next_state = ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          next_state = ST_IDLE;
          do_abort   = 1'b1;
        end else if (timer_zero_c) begin
          next_state = ST_SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          next_state = ST_IDLE;
          do_abort   = 1'b1;
        end else begin
          capture    = 1'b1;
          next_state = (vec == LAST_VEC) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign mismatch = (y != EXPECTED[vec]);
  // Includes the mismatch of the vector being captured this edge
  assign err_next = (capture && mismatch && (err_count != ERR_MAX)) ?
                    (err_count + ERR_W'(1)) : err_count;

  // Output and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      captured      <= '0;
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else begin
      busy <= (next_state == ST_DRIVE) || (next_state == ST_SETTLE) ||
              (next_state == ST_SAMPLE);
      done <= (next_state == ST_DONE);

      // vec holds its last value through DONE and is parked at 0 in IDLE
      if (next_state == ST_IDLE) begin
        vec <= '0;
      end else if (capture && (next_state == ST_DRIVE)) begin
        vec <= vec + VEC_W'(1);
      end

      if (accept_start) begin
        captured      <= '0;
        err_count     <= '0;
        first_err     <= '0;
        first_err_vld <= 1'b0;
        pass          <= 1'b0;
      end

      if (capture) begin
        captured[vec] <= y;
        err_count     <= err_next;
        if (mismatch && !first_err_vld) begin
          first_err     <= vec;
          first_err_vld <= 1'b1;
        end
        if (next_state == ST_DONE) begin
          pass <= (err_next == '0);
        end
      end

      if (do_abort) begin
        pass <= 1'b0;
      end
    end
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, idle cycles per vector before y is sampled (legal 0..15).
REQ-002 Parameter EXPECTED, default 32'h0000_0000, golden output; bit i = required y for vector i.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a 32-vector sweep; sampled only in IDLE.
REQ-007 abort  input  1  terminate a sweep; no result reported.
REQ-008 y  input  1  combinational DUT response to vec.
REQ-009 vec  output  5  stimulus {A,B,C,D,E}; A = vec[4].
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 captured  output  32  sampled y per vector; bit i = vector i.
REQ-014 err_count  output  6  mismatch count, 0..32.
REQ-015 first_err  output  5  lowest vector index that mismatched.
REQ-016 first_err_vld  output  1  first_err is meaningful.

Function
REQ-017 States IDLE, DRIVE, SETTLE, SAMPLE, DONE: IDLE->DRIVE on start; DRIVE->SETTLE (or SAMPLE if SETTLE_CYCLES=0); SETTLE->SAMPLE after SETTLE_CYCLES cycles; SAMPLE->DRIVE with index+1, or SAMPLE->DONE at index 31; DONE->IDLE after one cycle.
REQ-018 Each vector is held on vec for exactly SETTLE_CYCLES+2 cycles (DRIVE, SETTLE_CYCLES x SETTLE, SAMPLE); y is captured at the clock edge ending the SAMPLE cycle.
REQ-019 vec increments 0..31 in order; no wrap to 0 is driven within a sweep; after DONE, vec returns to 0.
REQ-020 On capture: captured[i] <= y; if y != EXPECTED[i], err_count increments; if first_err_vld=0, first_err <= i and first_err_vld <= 1.
REQ-021 err_count saturates at 32 and never wraps.
REQ-022 Accepting start clears captured, err_count, first_err, first_err_vld and pass in the same edge.
REQ-023 done=1 only in DONE; pass <= (err_count==0) on entry to DONE and holds until next accepted start.
REQ-024 busy=1 in DRIVE, SETTLE and SAMPLE; 0 in IDLE and DONE.
REQ-025 start while busy or in DONE is ignored.
REQ-026 abort in any busy state: next state IDLE, vec=0, done never pulses, pass=0, captured/err_count frozen at partial values.
REQ-027 start and abort together in IDLE: abort wins, start is ignored.
REQ-028 Sweep latency: done asserts 32*(SETTLE_CYCLES+2) cycles after the start edge (128 with default).

Reset
REQ-029 rst_n low, at any time including mid-sweep: state IDLE, vec=0, busy=0, done=0, pass=0, captured=0, err_count=0, first_err=0, first_err_vld=0, settle counter=0.
REQ-030 Release of rst_n is not a start; start must be asserted after release.

Structure
REQ-031 Shared package tt_pkg holds the state enum, VEC_W=5, NUM_VEC=32 and ERR_W=6.
REQ-032 One sub-module, tt_settle_timer: loadable down-counter with a zero flag, used for the SETTLE wait.

Verification
REQ-033 Default params, y tied 0, start pulse -> done at cycle 128, pass=1, err_count=0, captured=32'h0, first_err_vld=0.
REQ-034 y = XOR of vec bits, EXPECTED=32'h9669_6996 -> captured=32'h9669_6996, pass=1.
REQ-035 EXPECTED=32'hFFFF_FFFF, y tied 0 -> err_count=32 (saturated), first_err=0, first_err_vld=1, pass=0.
REQ-036 y=0 except forced 1 when vec=13, EXPECTED=0 -> err_count=1, first_err=13, pass=0.
REQ-037 Abort while vec=10 -> busy=0 next cycle, vec=0, no done pulse; a start pulse during the sweep is ignored.
REQ-038 rst_n pulsed low mid-sweep (vec=20) -> all outputs zero immediately; a new start gives a full 128-cycle sweep.
